// File: rtl/uart_transmit_if.sv
// uart_transmit_if: groups the byte handshake and serial line of the UART transmitter.
// Signals: Send/Din (request, byte), tx_out (serial line), Sent (ack), busy.
// master = requester side, slave = transmitter side.
interface uart_transmit_if;
  logic       Send;
  logic [7:0] Din;
  logic       tx_out;
  logic       Sent;
  logic       busy;

  modport master (output Send, output Din, input tx_out, input Sent, input busy);
  modport slave  (input Send, input Din, output tx_out, output Sent, output busy);
endinterface

// File: rtl/uart_transmit.sv
// uart_transmit: serialises one byte per four-phase Send/Sent handshake as
// start, 8 data bits LSB first, parity, stop; each bit lasts BIT_CYCLES clocks.
// Ports: clk, reset (async active-low), bus (slave modport: Send, Din, tx_out, Sent, busy).
module uart_transmit #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  uart_transmit_if.slave bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ACK
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic           tx_q;
  logic           sent_q;
  logic           busy_q;
  logic           bit_done;

  // Cycle counter wraps at the end of every bit period.
  assign bit_done = (cnt_q == CNT_LAST);
  assign cnt_d    = bit_done ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          sent_q <= 1'b0;
          if (bus.Send) begin
            // Byte and parity are captured here so later Din changes cannot
            // disturb the frame; the start bit goes out on this same edge.
            shift_q <= bus.Din;
            par_q   <= (^bus.Din) ^ PARITY_ODD;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this shift.
              tx_q  <= shift_q[1];
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            sent_q  <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          tx_q <= 1'b1;
          // Requester must drop Send before another frame can be accepted.
          if (!bus.Send) begin
            sent_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          sent_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.Sent   = sent_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: directed tests for uart_transmit with BIT_CYCLES = 10.
// Two instances: odd parity (default) and even parity.
// Outputs sampled on the falling clock edge; inputs driven there too.
module tb_uart_transmit;

  logic clk;
  logic reset;
  bit   sel;
  int   nvec;
  int   nerr;

  uart_transmit_if ifo ();
  uart_transmit_if ife ();

  uart_transmit #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_ODD(1'b1)) dut_odd (
    .clk   (clk),
    .reset (reset),
    .bus   (ifo)
  );

  uart_transmit #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_ODD(1'b0)) dut_even (
    .clk   (clk),
    .reset (reset),
    .bus   (ife)
  );

  wire tx_s   = sel ? ife.tx_out : ifo.tx_out;
  wire sent_s = sel ? ife.Sent   : ifo.Sent;
  wire busy_s = sel ? ife.busy   : ifo.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic [7:0] d);
    if (sel) begin
      ife.Send = s;
      ife.Din  = d;
    end else begin
      ifo.Send = s;
      ifo.Din  = d;
    end
  endtask

  // Sends one frame and checks every cycle: tx bit, busy=1, Sent=0 for cycles
  // 1..110, then Sent=1 on cycle 111. late_at/drop_at are frame cycle indices
  // (-1 = unused) at which Din is changed or Send is dropped.
  task automatic send_frame(input logic [7:0] din, input logic par_exp,
                            input int late_at, input logic [7:0] late_din,
                            input int drop_at);
    logic [10:0] expv;
    logic        eb;
    expv = {1'b1, par_exp, din, 1'b0};
    @(negedge clk);
    drive(1'b1, din);
    @(posedge clk);
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      eb = expv[k / 10];
      nvec++;
      if (tx_s !== eb || busy_s !== 1'b1 || sent_s !== 1'b0) begin
        nerr++;
        $display("FAIL frame din=%h cyc=%0d: tx=%b busy=%b sent=%b, expected tx=%b busy=1 sent=0",
                 din, k + 1, tx_s, busy_s, sent_s, eb);
      end
      if (k == late_at) drive(1'b1, late_din);
      if (k == drop_at) drive(1'b0, din);
    end
    @(negedge clk);
    nvec++;
    if (sent_s !== 1'b1 || tx_s !== 1'b1) begin
      nerr++;
      $display("FAIL sent_rise din=%h: sent=%b tx=%b, expected sent=1 tx=1", din, sent_s, tx_s);
    end
  endtask

  task automatic release_send();
    drive(1'b0, 8'h00);
    @(negedge clk);
    nvec++;
    if (sent_s !== 1'b0 || busy_s !== 1'b0 || tx_s !== 1'b1) begin
      nerr++;
      $display("FAIL release: sent=%b busy=%b tx=%b, expected sent=0 busy=0 tx=1", sent_s, busy_s, tx_s);
    end
  endtask

  task automatic test_reset();
    sel   = 1'b0;
    reset = 1'b0;
    drive(1'b1, 8'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++;
      if (tx_s !== 1'b1 || sent_s !== 1'b0 || busy_s !== 1'b0) begin
        nerr++;
        $display("FAIL reset_hold cyc=%0d: tx=%b sent=%b busy=%b, expected 1 0 0", i, tx_s, sent_s, busy_s);
      end
    end
    drive(1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_handshake();
    bit bad;
    sel = 1'b0;
    send_frame(8'h41, 1'b1, -1, 8'h00, -1);
    // Send held high: Sent stays, line idle, no second frame.
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sent_s !== 1'b1 || tx_s !== 1'b1) bad = 1'b1;
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL hold_send: sent=%b tx=%b at end, expected sent=1 tx=1 throughout", sent_s, tx_s);
    end
    release_send();
    send_frame(8'h55, 1'b1, -1, 8'h00, -1);
    release_send();
  endtask

  task automatic test_parity();
    sel = 1'b0;
    send_frame(8'h00, 1'b1, -1, 8'h00, -1);
    release_send();
    send_frame(8'hFF, 1'b1, -1, 8'h00, -1);
    release_send();
    send_frame(8'h01, 1'b0, -1, 8'h00, -1);
    release_send();
    sel = 1'b1;
    send_frame(8'h01, 1'b1, -1, 8'h00, -1);
    release_send();
    sel = 1'b0;
  endtask

  task automatic test_data_stability();
    sel = 1'b0;
    send_frame(8'hA5, 1'b1, 1, 8'h3C, -1);
    release_send();
  endtask

  task automatic test_send_drop();
    sel = 1'b0;
    // Send drops at cycle 51; frame completes and Sent pulses for one cycle.
    send_frame(8'h5A, 1'b1, -1, 8'h00, 50);
    release_send();
  endtask

  task automatic test_midframe_reset();
    bit bad;
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'h41);
    @(posedge clk);
    repeat (35) @(negedge clk);
    // Cycle 35 carries data bit 2 of 0x41 (0), so a return to 1 is visible.
    reset = 1'b0;
    #1;
    nvec++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0 || sent_s !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: tx=%b busy=%b sent=%b, expected 1 0 0", tx_s, busy_s, sent_s);
    end
    drive(1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (sent_s !== 1'b0 || tx_s !== 1'b1 || busy_s !== 1'b0) bad = 1'b1;
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL post_reset_idle: line not idle or Sent issued after aborted frame (sent=%b tx=%b)",
               sent_s, tx_s);
    end
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    sel      = 1'b0;
    reset    = 1'b0;
    ifo.Send = 1'b0;
    ifo.Din  = 8'h00;
    ife.Send = 1'b0;
    ife.Din  = 8'h00;
    test_reset();
    test_basic_handshake();
    test_parity();
    test_data_stability();
    test_send_drop();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- UART serial transmitter; the sending counterpart of the existing getter/receive UART receiver.
- Accepts a parallel byte under a four-phase request/acknowledge handshake.
- Emits one frame on `tx_out`: start bit, 8 data bits LSB first, parity bit, stop bit.
- Frame format and baud match the receiver, so `tx_out` can drive a board pin or loop back into the receiver's `ser_in`.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate.
- PARITY_ODD, 1: 1 = odd parity (matches receiver); 0 = even parity.
- Derived constant BIT_CYCLES = CLK_FREQ / BAUD_RATE (integer divide), e.g. 5208. Not overridable.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Send  input  1  transmit request; level, held high by the requester until Sent.
- Din  input  8  byte to transmit; sampled on the accepting edge only.
- tx_out  output  1  serial line, idle high; registered output.
- Sent  output  1  acknowledge; high from frame completion until Send drops.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset = 0:
  - state = IDLE, tx_out = 1, Sent = 0, busy = 0.
  - Bit and cycle counters = 0; shift register = 0.
  - Takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, ACK.
- IDLE:
  - tx_out = 1.
  - If Send = 1 on an edge: latch Din into the shift register and compute parity = ^Din XOR PARITY_ODD; go to START.
  - tx_out falls on that same edge, so the start bit begins one cycle after Send is first sampled high.
- START: tx_out = 0 for exactly BIT_CYCLES cycles, then DATA.
- DATA:
  - tx_out = shift[0] for BIT_CYCLES cycles per bit.
  - Shift right after each bit.
  - 3-bit counter; after bit index 7 completes, go to PARITY.
- PARITY: tx_out = latched parity bit for BIT_CYCLES cycles, then STOP.
- STOP: tx_out = 1 for BIT_CYCLES cycles, then ACK.
- ACK:
  - tx_out = 1, Sent = 1.
  - Stay while Send = 1; when Send = 0, go to IDLE with Sent = 0 on the next cycle.
- Frame length is 11 × BIT_CYCLES cycles from the first low cycle of tx_out to entry into ACK.
- Cycle counter:
  - Width is ceil(log2(BIT_CYCLES)).
  - Counts 0..BIT_CYCLES-1, then wraps to 0 and advances to the next bit.
  - Cleared on entry to START.
- tx_out is driven from a flop, never combinationally from state, so it is glitch-free.
- Din changes after acceptance have no effect on the frame in progress.
- Send held high after Sent: no retransmission. A new frame requires Send low for at least one cycle, then high again.
- Send dropping mid-frame: ignored; the frame completes. In ACK, Send is already low, so the FSM passes through ACK for one cycle with Sent pulsed high for that one cycle.
- Reset asserted mid-frame: the frame is aborted immediately, tx_out returns to 1, and no Sent is issued.
- Back-to-back frames: separated by at least one stop bit plus the ACK/IDLE cycles; there is never a zero-gap frame.

Test Plan:
- Bench parameters: CLK_FREQ=1000, BAUD_RATE=100, so BIT_CYCLES=10, unless a scenario states otherwise.
- Reset: hold reset=0 for 5 cycles with Send=1 → tx_out=1, Sent=0, busy=0 throughout. Drive reset low mid-frame (cycle 35 of a frame) → tx_out=1 asynchronously, busy=0; after release, no Sent.
- Din=0x41, Send=1 → tx_out sequence per 10-cycle bit: 0, 1,0,0,0,0,0,1,0, parity 1, stop 1; Sent rises at cycle 111 after acceptance; busy high cycles 1–110.
- Parity edge values: Din=0x00 → parity bit 1; Din=0xFF → 1; Din=0x01 → 0. With PARITY_ODD=0 and Din=0x01 → parity bit 1.
- Handshake: hold Send=1 for 300 cycles after Sent → exactly one frame and Sent stays high; drop Send → Sent=0 next cycle. Re-raise Send with Din=0x55 → a second frame starts, 0x55 bits 1,0,1,0,1,0,1,0, parity 1.
- Data stability: change Din from 0xA5 to 0x3C on cycle 2 of a frame → the serialized data bits are still those of 0xA5.
- Loopback at CLK_FREQ=100_000_000, BAUD_RATE=19_200: connect tx_out to the getter's ser_in and send 0x00, 0x5A, 0xFF → the receiver raises Receive with rxData equal to each byte and parityErr=0.
